mc_control: RTL
===============

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter WAIT_LIMIT, default 15: maximum consecutive cycles a memory state waits for mem_ready before a bus error.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  6  instruction[31:26] from the instruction register.
REQ-005 mem_ready  input  1  memory completes the current read/write this cycle.
REQ-006 aluOP  output  2  to ALU decoder: 00 add, 01 subtract, 10 use funct field.
REQ-007 ALUSrcA  output  1  0 = PC, 1 = register A.
REQ-008 ALUSrcB  output  2  00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
REQ-009 PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-010 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst  output  1 each  standard multicycle datapath strobes.
REQ-011 bus_err  output  1  one-cycle pulse on memory timeout.
REQ-012 illegal_op  output  1  one-cycle pulse on unsupported opcode.
REQ-013 state_dbg  output  4  current state encoding.

Function
REQ-014 States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, JUMP, plus ADDI_EXEC and ADDI_WB when configured.
REQ-015 All strobes are Moore outputs decoded from state, except IRWrite and PCWrite in FETCH, which are qualified by mem_ready.
REQ-016 IDLE: all outputs 0; always advances to FETCH next cycle.
REQ-017 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, aluOP=00, PCSource=00; holds until mem_ready=1; in the mem_ready cycle it asserts IRWrite=1 and PCWrite=1 and goes to DECODE.
REQ-018 DECODE: ALUSrcA=0, ALUSrcB=11, aluOP=00. Next state by opcode: 100011/101011 -> MEM_ADDR, 000000 -> R_EXEC, 000100 -> BRANCH, 000010 -> JUMP, 001000 -> ADDI_EXEC (when configured). Any other opcode pulses illegal_op and goes to FETCH.
REQ-019 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, aluOP=00. Goes to MEM_RD for opcode 100011 and to MEM_WR for opcode 101011.
REQ-020 MEM_RD: MemRead=1, IorD=1; holds until mem_ready, then goes to MEM_WB.
REQ-021 MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0; then goes to FETCH.
REQ-022 MEM_WR: MemWrite=1, IorD=1; holds until mem_ready, then goes to FETCH.
REQ-023 R_EXEC: ALUSrcA=1, ALUSrcB=00, aluOP=10; then goes to R_WB.
REQ-024 R_WB: RegWrite=1, RegDst=1, MemtoReg=0; then goes to FETCH.
REQ-025 BRANCH: ALUSrcA=1, ALUSrcB=00, aluOP=01, PCWriteCond=1, PCSource=01; then goes to FETCH.
REQ-026 JUMP: PCWrite=1, PCSource=10; then goes to FETCH.
REQ-027 Wait counter: clears on entry to FETCH, MEM_RD or MEM_WR and increments each cycle mem_ready=0 in those states.
REQ-028 When the wait counter reaches WAIT_LIMIT with mem_ready=0: pulse bus_err, assert no write strobe that cycle, and go to IDLE.
REQ-029 mem_ready=1 in the same cycle the limit is reached: the access completes and no bus_err is raised; ready wins.
REQ-030 Counter width is clog2(WAIT_LIMIT+1) and saturates; it never wraps.
REQ-031 mem_ready is ignored in every non-memory state.

Reset
REQ-032 reset_n low asynchronously forces state=IDLE, wait counter=0, and all outputs to 0 (aluOP=00, state_dbg=IDLE).
REQ-033 Reset asserted mid-access abandons the access; the first fetch begins two cycles after reset_n rises.

Configuration
REQ-034 Macro MC_CONTROL_ADDI_EN defined: ADDI_EXEC (ALUSrcA=1, ALUSrcB=10, aluOP=00) is followed by ADDI_WB (RegWrite=1, RegDst=0, MemtoReg=0) and then FETCH.
REQ-035 Macro MC_CONTROL_ADDI_EN undefined: the ADDI states do not exist and opcode 001000 is illegal per REQ-018.

Structure
REQ-036 Package mips_pkg holds the opcode constants, the state enum with fixed 4-bit encodings, and the aluOP/ALUSrcB/PCSource encodings.
REQ-037 One sub-module, mem_wait_timer, holds the wait counter, its saturation logic and the limit compare.

Verification
REQ-038 Reset, release, opcode=000000, mem_ready=1 on first FETCH cycle -> states IDLE, FETCH, DECODE, R_EXEC (aluOP=10), R_WB (RegWrite=1, RegDst=1), FETCH.
REQ-039 opcode=100011 with mem_ready delayed 3 cycles in MEM_RD -> MemRead=1/IorD=1 held 4 cycles, then MEM_WB with MemtoReg=1.
REQ-040 opcode=000100 -> BRANCH with aluOP=01, PCWriteCond=1, PCSource=01, then FETCH.
REQ-041 WAIT_LIMIT=15, mem_ready held 0 in FETCH -> bus_err pulses once after 15 wait cycles, IRWrite stays 0, next state IDLE; a repeat run with mem_ready=1 in cycle 15 -> no bus_err.
REQ-042 opcode=001000 -> ADDI path with the macro defined; illegal_op pulse and return to FETCH without it.
REQ-043 reset_n dropped during MEM_WR -> MemWrite=0 immediately and state_dbg=IDLE.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller.
// MC_CONTROL_ADDI_EN adds the ADDI_EXEC/ADDI_WB states.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_src_e;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10
`ifdef MC_CONTROL_ADDI_EN
        ,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
`endif
    } state_e;

    // States that wait on mem_ready and are guarded by the timeout.
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for memory states; flags expiry when the
// limit has been reached and memory is still not ready.
module mem_wait_timer #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start_i,
    input  logic active_i,
    input  logic ready_i,
    output logic expired_o
);

    localparam int unsigned CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

    logic [CW-1:0] count_q, count_d;
    logic          at_limit;

    assign at_limit = (count_q == LIMIT);

    always_comb begin
        count_d = count_q;
        if (start_i) begin
            count_d = '0;
        end else if (active_i && !ready_i && !at_limit) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Ready in the limit cycle completes the access instead of expiring.
    assign expired_o = active_i && !ready_i && at_limit;

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS main control FSM with memory-wait timeout.
// Define MC_CONTROL_ADDI_EN to support ADDI (opcode 001000).
module mc_control
    import mips_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [1:0] aluOP,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       bus_err,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    state_e     state_q, state_d;
    logic       timeout;
    logic       mem_entry;
    alu_op_e    alu_op;
    alu_src_b_e src_b;
    pc_src_e    pc_src;

    assign mem_entry = is_mem_state(state_d) && (state_d != state_q);

    mem_wait_timer #(
        .WAIT_LIMIT(WAIT_LIMIT)
    ) u_wait_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_i  (mem_entry),
        .active_i (is_mem_state(state_q)),
        .ready_i  (mem_ready),
        .expired_o(timeout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        illegal_op = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready)    state_d = S_DECODE;
                else if (timeout) state_d = S_IDLE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_CONTROL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EXEC;
`endif
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready)    state_d = S_MEM_WB;
                else if (timeout) state_d = S_IDLE;
            end
            S_MEM_WB: state_d = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready)    state_d = S_FETCH;
                else if (timeout) state_d = S_IDLE;
            end
            S_R_EXEC: state_d = S_R_WB;
            S_R_WB:   state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
`ifdef MC_CONTROL_ADDI_EN
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        alu_op      = ALU_ADD;
        src_b       = SRCB_REG;
        pc_src      = PCSRC_ALU;
        ALUSrcA     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                src_b   = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE:   src_b = SRCB_IMM_SH2;
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                src_b   = SRCB_IMM;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = !timeout;
                IorD     = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                alu_op  = ALU_FUNCT;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                alu_op      = ALU_SUB;
                PCWriteCond = 1'b1;
                pc_src      = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                pc_src  = PCSRC_JUMP;
            end
`ifdef MC_CONTROL_ADDI_EN
            S_ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                src_b   = SRCB_IMM;
            end
            S_ADDI_WB: RegWrite = 1'b1;
`endif
            default: ;
        endcase
    end

    assign aluOP     = alu_op;
    assign ALUSrcB   = src_b;
    assign PCSource  = pc_src;
    assign bus_err   = timeout;
    assign state_dbg = state_q;

endmodule
